// File: rtl/scr_pkg.sv
// Shared constants and FSM state type for the x^58+x^39+1 scrambler/descrambler pair.
`timescale 1ns/1ps
package scr_pkg;

  localparam int unsigned SCR_LEN    = 58;
  localparam int unsigned TAP_A      = 38;
  localparam int unsigned TAP_B      = 57;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WARMUP_CYC = 60;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/descrambler_core.sv
// Self-synchronous descrambler: input register, 58-bit history of received bits, registered output.
`timescale 1ns/1ps
module descrambler_core
  import scr_pkg::*;
(
  input  logic clk_25G,
  input  logic rst_n,
  input  logic data_scrambled_serial,
  output logic d_q
);

  logic               serial_in;
  logic [SCR_LEN-1:0] shift;
  logic               d;

  always_comb d = serial_in ^ shift[TAP_A] ^ shift[TAP_B];

  // The history holds received (scrambled) bits, which is what makes the descrambler self-synchronising.
  always_ff @(posedge clk_25G or negedge rst_n) begin
    if (!rst_n) begin
      serial_in <= 1'b0;
      shift     <= '0;
      d_q       <= 1'b0;
    end else begin
      serial_in <= data_scrambled_serial;
      shift     <= {shift[SCR_LEN-2:0], serial_in};
      d_q       <= d;
    end
  end

endmodule

// File: rtl/descrambler_deser.sv
// Descrambler with warm-up FSM and MSB-first 32-bit deserialiser.
// Optional error monitor (descrambled-ones counter) enabled by `define DESCR_ERR_MON_EN.
`timescale 1ns/1ps
module descrambler_deser
  import scr_pkg::*;
(
  input  logic              clk_25G,
  input  logic              rst_n,
  input  logic              data_scrambled_serial,
`ifdef DESCR_ERR_MON_EN
  input  logic              clr_err,
`endif
  output logic [WORD_W-1:0] data_word,
  output logic              word_valid,
`ifdef DESCR_ERR_MON_EN
  output logic              sync_done,
  output logic [15:0]       err_cnt
`else
  output logic              sync_done
`endif
);

  localparam logic [5:0] FILL_LAST = 6'(WARMUP_CYC - 1);
  localparam logic [4:0] BIT_LAST  = 5'(WORD_W - 1);

  state_t            state;
  state_t            next_state;
  logic              run;
  logic              d_q;
  logic [5:0]        fill_cnt;
  logic [4:0]        bit_cnt;
  logic [WORD_W-1:1] asm_word;

  descrambler_core u_core (
    .clk_25G               (clk_25G),
    .rst_n                 (rst_n),
    .data_scrambled_serial (data_scrambled_serial),
    .d_q                   (d_q)
  );

  always_ff @(posedge clk_25G or negedge rst_n) begin
    if (!rst_n) begin
      state <= WARMUP;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    run        = 1'b0;
    case (state)
      WARMUP: if (fill_cnt == FILL_LAST) next_state = RUN;
      RUN:    run = 1'b1;
      default: next_state = WARMUP;
    endcase
  end

  assign sync_done = run;

  always_ff @(posedge clk_25G or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (state == WARMUP) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Bit 0 of a word is the last bit received, so it goes straight into data_word and needs no storage.
  always_ff @(posedge clk_25G or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      asm_word   <= '0;
      data_word  <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (run) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == BIT_LAST) begin
          data_word  <= {asm_word, d_q};
          word_valid <= 1'b1;
        end else begin
          asm_word[BIT_LAST - bit_cnt] <= d_q;
        end
      end
    end
  end

`ifdef DESCR_ERR_MON_EN
  always_ff @(posedge clk_25G or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (run && d_q && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
